// File: rtl/inst_fetch.sv
// ============================================================================
// inst_fetch
// ----------------------------------------------------------------------------
// Sequential instruction fetch unit with a small prefetch FIFO.
//
// A fetch_pc register addresses the instruction memory directly (mem_addr).
// The memory answers combinationally on mem_data in the same cycle. Every
// cycle in which the FIFO has room, or is being drained at its head, the pair
// {fetch_pc, mem_data} is captured into the FIFO and fetch_pc advances by one
// word. The consumer sees the FIFO head through a valid/ready handshake.
// A redirect flushes the FIFO and restarts fetch at the word-aligned target.
// A target with nonzero low bits sets a sticky misaligned flag.
//
// Parameters
//   RESET_PC : fetch address after reset (bits [1:0] forced to zero)
//   DEPTH    : FIFO entry count, one of 2, 4 or 8
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   mem_addr       out  [14:0] byte address to instruction memory
//   mem_data       in   [31:0] instruction word at mem_addr (same cycle)
//   redirect_valid in   branch/jump redirect request
//   redirect_pc    in   [14:0] redirect target byte address
//   out_valid      out  FIFO head holds a valid instruction
//   out_ready      in   consumer accepts the head this cycle
//   out_inst       out  [31:0] instruction at FIFO head
//   out_pc         out  [14:0] byte address of out_inst
//   misaligned     out  sticky: some redirect target was not word aligned
// ============================================================================
module inst_fetch #(
   parameter logic [14:0] RESET_PC = 15'd0,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [14:0] mem_addr,
   input  logic [31:0] mem_data,
   input  logic        redirect_valid,
   input  logic [14:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [14:0] out_pc,
   output logic        misaligned
);

   // Pointer and occupancy widths; a pointer needs at least one bit.
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [PW-1:0] PTR_ZERO   = {PW{1'b0}};
   localparam logic [PW-1:0] PTR_ONE    = PW'(1);
   localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
   localparam logic [14:0]   PC_STEP    = 15'd4;
   localparam logic [14:0]   RESET_ADDR = {RESET_PC[14:2], 2'b00};

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [14:0]   fetch_pc_q,   fetch_pc_d;
   logic [PW-1:0] rd_ptr_q,     rd_ptr_d;
   logic [PW-1:0] wr_ptr_q,     wr_ptr_d;
   logic [CW-1:0] count_q,      count_d;
   logic          misaligned_q, misaligned_d;
   logic [14:0]   pc_store_q   [DEPTH];
   logic [14:0]   pc_store_d   [DEPTH];
   logic [31:0]   inst_store_q [DEPTH];
   logic [31:0]   inst_store_d [DEPTH];

   logic          pop_s;
   logic          push_s;

   // -------------------------------------------------------------------------
   // Handshake decode
   // -------------------------------------------------------------------------
   assign out_valid = (count_q != CNT_ZERO);
   assign pop_s     = out_valid && out_ready;
   // A pop frees the head slot, so a full FIFO can still accept this cycle.
   assign push_s    = !redirect_valid && ((count_q < CNT_FULL) || pop_s);

   // Memory is addressed straight from the fetch register.
   assign mem_addr   = fetch_pc_q;

   // Head of the FIFO comes from registered storage only, never from mem_data.
   assign out_inst   = inst_store_q[rd_ptr_q];
   assign out_pc     = pc_store_q[rd_ptr_q];
   assign misaligned = misaligned_q;

   // Next-state for fetch address, pointers, occupancy and sticky flag.
   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      misaligned_d = misaligned_q;

      if (redirect_valid) begin
         // Redirect wins over push and pop: the FIFO is emptied and any pop
         // offered in this cycle is discarded.
         fetch_pc_d = {redirect_pc[14:2], 2'b00};
         rd_ptr_d   = PTR_ZERO;
         wr_ptr_d   = PTR_ZERO;
         count_d    = CNT_ZERO;
         if (redirect_pc[1:0] != 2'b00) begin
            misaligned_d = 1'b1;
         end else begin
            misaligned_d = misaligned_q;
         end
      end else begin
         if (push_s) begin
            // 15-bit add wraps 0x7FFC back to 0x0000.
            fetch_pc_d = fetch_pc_q + PC_STEP;
            if (wr_ptr_q == PTR_LAST) begin
               wr_ptr_d = PTR_ZERO;
            end else begin
               wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
         end else begin
            fetch_pc_d = fetch_pc_q;
            wr_ptr_d   = wr_ptr_q;
         end

         if (pop_s) begin
            if (rd_ptr_q == PTR_LAST) begin
               rd_ptr_d = PTR_ZERO;
            end else begin
               rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
         end else begin
            rd_ptr_d = rd_ptr_q;
         end

         // Simultaneous push and pop leaves occupancy unchanged.
         if (push_s && !pop_s) begin
            count_d = count_q + CNT_ONE;
         end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_ONE;
         end else begin
            count_d = count_q;
         end
      end
   end

   // Next-state for FIFO storage: write {fetch_pc, mem_data} at the tail on push.
   always_comb begin
      pc_store_d   = pc_store_q;
      inst_store_d = inst_store_q;
      if (push_s) begin
         pc_store_d[wr_ptr_q]   = fetch_pc_q;
         inst_store_d[wr_ptr_q] = mem_data;
      end else begin
         pc_store_d[wr_ptr_q]   = pc_store_q[wr_ptr_q];
         inst_store_d[wr_ptr_q] = inst_store_q[wr_ptr_q];
      end
   end

   // Control registers; reset empties the FIFO immediately, without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q   <= RESET_ADDR;
         rd_ptr_q     <= PTR_ZERO;
         wr_ptr_q     <= PTR_ZERO;
         count_q      <= CNT_ZERO;
         misaligned_q <= 1'b0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         misaligned_q <= misaligned_d;
      end
   end

   // FIFO storage registers; cleared on reset so the idle head reads as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_store_q[i]   <= 15'd0;
            inst_store_q[i] <= 32'd0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_store_q[i]   <= pc_store_d[i];
            inst_store_q[i] <= inst_store_d[i];
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// ============================================================================
// tb_inst_fetch
// ----------------------------------------------------------------------------
// Self-checking bench for inst_fetch (default parameters). The memory returns
// {17'd0, addr}. A queue-based reference model tracks the fetch address, the
// buffered instruction addresses and the sticky misaligned flag. Outputs are
// sampled on the falling edge; inputs change right after sampling.
// ============================================================================
module tb_inst_fetch;

   localparam int          DEPTH    = 2;
   localparam logic [14:0] RESET_PC = 15'd0;

   logic        clk;
   logic        rst;
   logic [14:0] mem_addr;
   logic [31:0] mem_data;
   logic        redirect_valid;
   logic [14:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [14:0] out_pc;
   logic        misaligned;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [14:0] m_q[$];
   logic [14:0] m_fpc;
   logic        m_mis;

   inst_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .misaligned     (misaligned)
   );

   // Memory model: word at address A is A itself.
   assign mem_data = {17'd0, mem_addr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_q.delete();
      m_fpc = {RESET_PC[14:2], 2'b00};
      m_mis = 1'b0;
   endtask

   // One clock: drive inputs, advance model at the rising edge, return at the
   // falling edge. Must be entered at a falling edge.
   task automatic cycle(input logic rdy, input logic rv, input logic [14:0] rpc);
      int  sz;
      bit  pop;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(posedge clk);
      if (rv) begin
         m_q.delete();
         m_fpc = {rpc[14:2], 2'b00};
         if (rpc[1:0] != 2'b00) m_mis = 1'b1;
      end else begin
         sz  = m_q.size();
         pop = (sz != 0) && rdy;
         if (pop) void'(m_q.pop_front());
         if (sz < DEPTH || pop) begin
            m_q.push_back(m_fpc);
            m_fpc = m_fpc + 15'd4;
         end
      end
      @(negedge clk);
      redirect_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      out_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 15'd0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      n_checks++;
      if (out_pc !== 15'd0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
      n_checks++;
      if (out_inst !== 32'd0) begin n_fail++; $display("FAIL reset_inst: got %h expected 0", out_inst); end
      n_checks++;
      if (mem_addr !== {RESET_PC[14:2], 2'b00}) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", mem_addr, {RESET_PC[14:2], 2'b00}); end
      n_checks++;
      if (misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned: got %b expected 0", misaligned); end
      rst = 1'b0;
   endtask

   task automatic test_stream();
      logic [14:0] exp_pc;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, 15'd0);
         exp_pc = 15'(4 * i);
         n_checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== {17'd0, exp_pc}) begin
            n_fail++;
            $display("FAIL stream[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                     i, out_valid, out_pc, out_inst, exp_pc, {17'd0, exp_pc});
         end
      end
   endtask

   task automatic test_backpressure();
      logic [14:0] exp_pc;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, 15'd0);
         n_checks++;
         if (out_valid !== 1'b1 || out_pc !== 15'd0) begin
            n_fail++;
            $display("FAIL stall_head[%0d]: got v=%b pc=%h expected v=1 pc=0", i, out_valid, out_pc);
         end
      end
      n_checks++;
      if (mem_addr !== 15'(4 * DEPTH)) begin n_fail++; $display("FAIL stall_addr: got %h expected %h", mem_addr, 15'(4 * DEPTH)); end
      for (int i = 1; i < 3; i++) begin
         cycle(1'b1, 1'b0, 15'd0);
         exp_pc = 15'(4 * i);
         n_checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL drain[%0d]: got v=%b pc=%h expected v=1 pc=%h", i, out_valid, out_pc, exp_pc);
         end
      end
   endtask

   task automatic test_redirect();
      do_reset();
      cycle(1'b0, 1'b0, 15'd0);
      cycle(1'b0, 1'b0, 15'd0);
      cycle(1'b1, 1'b1, 15'h0100);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_gap: got v=%b expected 0", out_valid); end
      cycle(1'b1, 1'b0, 15'd0);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 15'h0100) begin n_fail++; $display("FAIL redir_first: got v=%b pc=%h expected v=1 pc=0100", out_valid, out_pc); end
      cycle(1'b1, 1'b0, 15'd0);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 15'h0104) begin n_fail++; $display("FAIL redir_second: got v=%b pc=%h expected v=1 pc=0104", out_valid, out_pc); end
      n_checks++;
      if (misaligned !== 1'b0) begin n_fail++; $display("FAIL redir_aligned_flag: got %b expected 0", misaligned); end
   endtask

   task automatic test_misaligned();
      cycle(1'b1, 1'b1, 15'h0102);
      n_checks++;
      if (out_valid !== 1'b0 || misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_set: got v=%b mis=%b expected v=0 mis=1", out_valid, misaligned); end
      cycle(1'b1, 1'b0, 15'd0);
      n_checks++;
      if (out_pc !== 15'h0100 || out_inst !== 32'h0000_0100) begin n_fail++; $display("FAIL mis_target: got pc=%h inst=%h expected pc=0100 inst=00000100", out_pc, out_inst); end
      cycle(1'b1, 1'b1, 15'h0200);
      cycle(1'b1, 1'b0, 15'd0);
      n_checks++;
      if (misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_sticky: got %b expected 1", misaligned); end
      do_reset();
      n_checks++;
      if (misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b expected 0", misaligned); end
   endtask

   task automatic test_wrap();
      cycle(1'b1, 1'b1, 15'h7FFC);
      cycle(1'b1, 1'b0, 15'd0);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 15'h7FFC || out_inst !== 32'h0000_7FFC) begin n_fail++; $display("FAIL wrap_top: got v=%b pc=%h inst=%h expected v=1 pc=7ffc", out_valid, out_pc, out_inst); end
      cycle(1'b1, 1'b0, 15'd0);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 15'h0000) begin n_fail++; $display("FAIL wrap_zero: got v=%b pc=%h expected v=1 pc=0000", out_valid, out_pc); end
   endtask

   task automatic test_back_to_back();
      cycle(1'b1, 1'b1, 15'h0200);
      cycle(1'b1, 1'b1, 15'h0300);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got v=%b expected 0", out_valid); end
      cycle(1'b1, 1'b0, 15'd0);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 15'h0300) begin n_fail++; $display("FAIL b2b_first: got v=%b pc=%h expected v=1 pc=0300", out_valid, out_pc); end
      cycle(1'b1, 1'b0, 15'd0);
      n_checks++;
      if (out_pc !== 15'h0304) begin n_fail++; $display("FAIL b2b_second: got pc=%h expected 0304", out_pc); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 15'd0);
      n_checks++;
      if (out_valid !== 1'b1 || mem_addr !== 15'(4 * DEPTH)) begin n_fail++; $display("FAIL areset_full: got v=%b addr=%h expected v=1 addr=%h", out_valid, mem_addr, 15'(4 * DEPTH)); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_pc !== 15'd0 || out_inst !== 32'd0) begin n_fail++; $display("FAIL areset_immediate: got v=%b pc=%h inst=%h expected all 0", out_valid, out_pc, out_inst); end
      @(negedge clk);
      model_reset();
      rst = 1'b0;
      cycle(1'b1, 1'b0, 15'd0);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== {RESET_PC[14:2], 2'b00}) begin n_fail++; $display("FAIL areset_restart: got v=%b pc=%h expected v=1 pc=%h", out_valid, out_pc, {RESET_PC[14:2], 2'b00}); end
   endtask

   task automatic test_random();
      logic        rdy;
      logic        rv;
      logic [14:0] rpc;
      logic [14:0] exp_pc;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 11) == 0);
         rpc = 15'($urandom_range(0, 32767));
         cycle(rdy, rv, rpc);
         n_checks++;
         if (out_valid !== (m_q.size() != 0)) begin
            n_fail++;
            $display("FAIL rand_valid[%0d]: got %b expected %b", i, out_valid, (m_q.size() != 0));
         end else if (m_q.size() != 0) begin
            exp_pc = m_q[0];
            if (out_pc !== exp_pc || out_inst !== {17'd0, exp_pc}) begin
               n_fail++;
               $display("FAIL rand_head[%0d]: got pc=%h inst=%h expected pc=%h inst=%h", i, out_pc, out_inst, exp_pc, {17'd0, exp_pc});
            end
         end
         n_checks++;
         if (mem_addr !== m_fpc || misaligned !== m_mis) begin
            n_fail++;
            $display("FAIL rand_state[%0d]: got addr=%h mis=%b expected addr=%h mis=%b", i, mem_addr, misaligned, m_fpc, m_mis);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      out_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 15'd0;
      model_reset();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_misaligned();
      test_wrap();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 15'd0, meaning the fetch address loaded on reset (bits [1:0] ignored, treated as 0).
REQ-002 The block SHALL provide parameter DEPTH, default 2, meaning the fetch buffer entry count (legal values 2, 4, 8).
REQ-003 The block SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-004 The block SHALL provide port rst  input  1  asynchronous active-high reset.
REQ-005 The block SHALL provide port mem_addr  output  15  byte address driven to the instruction memory pc input.
REQ-006 The block SHALL provide port mem_data  input  32  little-endian word returned combinationally by the memory for mem_addr, in the same cycle.
REQ-007 The block SHALL provide port redirect_valid  input  1  branch/jump redirect request.
REQ-008 The block SHALL provide port redirect_pc  input  15  redirect target byte address.
REQ-009 The block SHALL provide port out_valid  output  1  buffer head holds a valid instruction.
REQ-010 The block SHALL provide port out_ready  input  1  consumer accepts the head this cycle.
REQ-011 The block SHALL provide port out_inst  output  32  instruction word at buffer head.
REQ-012 The block SHALL provide port out_pc  output  15  byte address of out_inst.
REQ-013 The block SHALL provide port misaligned  output  1  sticky flag: a redirect target had nonzero bits [1:0].

Function
REQ-014 The block SHALL hold a fetch_pc register and drive mem_addr = fetch_pc combinationally.
REQ-015 The block SHALL contain a DEPTH-entry FIFO of {pc[14:0], inst[31:0]} with read pointer, write pointer and count (0..DEPTH).
REQ-016 pop SHALL be defined as out_valid && out_ready; push SHALL be defined as !redirect_valid && (count < DEPTH || pop).
REQ-017 On push the block SHALL write {fetch_pc, mem_data} at the write pointer and set fetch_pc <= fetch_pc + 4, modulo 2^15 (32764 wraps to 0).
REQ-018 Without push, fetch_pc SHALL hold its value.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; a pop when full SHALL permit a push in that same cycle.
REQ-020 out_valid SHALL equal (count != 0); out_inst/out_pc SHALL come from the entry at the read pointer (registered storage, no combinational path from mem_data).
REQ-021 While out_valid && !out_ready, out_inst and out_pc SHALL remain stable.
REQ-022 Redirect SHALL take priority over push and pop: at the edge, count and both pointers are set to 0, and fetch_pc <= {redirect_pc[14:2], 2'b00}; a pop asserted in that cycle is discarded.
REQ-023 After redirect in cycle N, out_valid SHALL be 0 in cycle N+1, and the target SHALL be presented with out_valid=1 in cycle N+2 (redirect-to-valid latency 2 cycles).
REQ-024 misaligned SHALL set on any redirect with redirect_pc[1:0] != 0 and clear only on rst.
REQ-025 Back-to-back redirects SHALL each restart fetch; only the last target is fetched.
REQ-026 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-027 While rst=1 the block SHALL force fetch_pc = {RESET_PC[14:2],2'b00}, count=0, pointers=0, storage=0, misaligned=0, and therefore out_valid=0, out_inst=0, out_pc=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-029 After rst deasserts, the first rising edge SHALL push RESET_PC, and out_valid SHALL be 1 after that edge.

Verification
REQ-030 Bench memory model: word at address A = {17'd0, A}; out_ready=1 held; release reset -> out_pc sequence 0,4,8,12 on consecutive cycles, out_inst equal to out_pc.
REQ-031 out_ready=0 for 5 cycles after reset -> count saturates at DEPTH, mem_addr holds at 4*DEPTH, out_pc stays 0; raise out_ready -> out_pc sequence 0,4,8 with no gap or duplicate.
REQ-032 Redirect to 15'h0100 while the buffer holds 2 entries -> next cycle out_valid=0, following cycle out_pc=0x100, then 0x104; old entries never appear.
REQ-033 Redirect to 15'h0102 -> fetch resumes at 0x100 and misaligned=1 until rst.
REQ-034 Redirect to 15'h7FFC with out_ready=1 -> out_pc 0x7FFC, then 0x0000 (wrap).
REQ-035 Assert rst asynchronously mid-cycle with the buffer full -> out_valid falls before the next edge; after release, out_pc=RESET_PC.
